// File: rtl/mips_writeback_stage.sv
// MEM/WB writeback stage for the MIPS pipeline.
// Aligns sub-word load data (big-endian), picks the register-file write
// value from ALU / load / link sources, registers the result bundle with
// stall and flush control, and counts retired instructions.
module mips_writeback_stage #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int LINK_OFFSET    = 8,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      iValid,
  input  logic                      iStall,
  input  logic                      iFlush,
  input  logic                      iSig_regfile_write,
  input  logic                      iSig_MemtoReg,
  input  logic                      iSig_Link,
  input  logic [1:0]                iLoadSize,
  input  logic                      iLoadUnsigned,
  input  logic [REG_ADDR_WIDTH-1:0] iDest_reg,
  input  logic [DATA_WIDTH-1:0]     iPC,
  input  logic [DATA_WIDTH-1:0]     iread_from_ram,
  input  logic [DATA_WIDTH-1:0]     ialu_result,
  output logic                      oValid,
  output logic                      oRegWrite,
  output logic [REG_ADDR_WIDTH-1:0] oWriteReg,
  output logic [DATA_WIDTH-1:0]     odata2write2regfile,
  output logic [CNT_WIDTH-1:0]      oRetired
);

  // Number of address bits that select a byte inside one read word.
  localparam int LANE_BITS = $clog2(DATA_WIDTH / 8);

  logic [LANE_BITS-1:0]      byte_off;
  logic [LANE_BITS-1:0]      half_off;
  logic [7:0]                lane_shamt;
  logic [7:0]                drop_bits;
  logic [DATA_WIDTH-1:0]     shifted;
  logic [DATA_WIDTH-1:0]     field;
  logic [DATA_WIDTH-1:0]     field_mask;
  logic [DATA_WIDTH-1:0]     load_data;
  logic [DATA_WIDTH-1:0]     link_value;
  logic [DATA_WIDTH-1:0]     write_data;

  logic                      valid_q;
  logic                      regfile_write_q;
  logic [REG_ADDR_WIDTH-1:0] dest_q;
  logic [DATA_WIDTH-1:0]     data_q;
  logic [CNT_WIDTH-1:0]      retired_q;
  logic                      capture;

  // Byte offset 0 is the most significant byte; half loads ignore bit 0.
  assign byte_off   = ialu_result[LANE_BITS-1:0];
  assign half_off   = {byte_off[LANE_BITS-1:1], 1'b0};
  assign link_value = iPC + DATA_WIDTH'(LINK_OFFSET);
  assign capture    = !iFlush && !iStall;

  // Shift the addressed lane to the top of the word, then drop the bits
  // below it; the top bit of the shifted word is the field's sign bit.
  always_comb begin
    lane_shamt = 8'd0;
    drop_bits  = 8'd0;
    case (iLoadSize)
      2'b00: begin
        lane_shamt = 8'({byte_off, 3'b000});
        drop_bits  = 8'(DATA_WIDTH - 8);
      end
      2'b01: begin
        lane_shamt = 8'({half_off, 3'b000});
        drop_bits  = 8'(DATA_WIDTH - 16);
      end
      2'b10: begin
        if (DATA_WIDTH == 64) begin
          lane_shamt = 8'({ialu_result[2], 5'b00000});
        end
        drop_bits = 8'(DATA_WIDTH - 32);
      end
      default: begin
        lane_shamt = 8'd0;
        drop_bits  = 8'd0;
      end
    endcase
    shifted    = iread_from_ram << lane_shamt;
    field      = shifted >> drop_bits;
    field_mask = {DATA_WIDTH{1'b1}} >> drop_bits;
    if (iLoadUnsigned || !shifted[DATA_WIDTH-1]) begin
      load_data = field;
    end else begin
      load_data = field | ~field_mask;
    end
  end

  // Link beats load data, which beats the ALU result.
  always_comb begin
    write_data = ialu_result;
    if (iSig_Link) begin
      write_data = link_value;
    end else if (iSig_MemtoReg) begin
      write_data = load_data;
    end
  end

  // Stage valid bit: flush squashes, stall holds, otherwise follow iValid.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_q <= 1'b0;
    end else if (iFlush) begin
      valid_q <= 1'b0;
    end else if (!iStall) begin
      valid_q <= iValid;
    end
  end

  // Payload fields are only loaded on a normal capture and held otherwise.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      regfile_write_q <= 1'b0;
      dest_q          <= '0;
      data_q          <= '0;
    end else if (capture) begin
      regfile_write_q <= iSig_regfile_write;
      dest_q          <= iDest_reg;
      data_q          <= write_data;
    end
  end

  // Retired-instruction counter, free-running wrap on overflow.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      retired_q <= '0;
    end else if (capture && iValid) begin
      retired_q <= retired_q + CNT_WIDTH'(1);
    end
  end

  assign oValid              = valid_q;
  assign oRegWrite           = valid_q && regfile_write_q && (dest_q != '0);
  assign oWriteReg           = dest_q;
  assign odata2write2regfile = data_q;
  assign oRetired            = retired_q;

endmodule

// File: tb/tb_mips_writeback_stage.sv
// Directed bench for mips_writeback_stage (32-bit data, 4-bit counter).
module tb_mips_writeback_stage;

  logic        clk;
  logic        rstn;
  logic        iValid;
  logic        iStall;
  logic        iFlush;
  logic        iSig_regfile_write;
  logic        iSig_MemtoReg;
  logic        iSig_Link;
  logic [1:0]  iLoadSize;
  logic        iLoadUnsigned;
  logic [4:0]  iDest_reg;
  logic [31:0] iPC;
  logic [31:0] iread_from_ram;
  logic [31:0] ialu_result;
  logic        oValid;
  logic        oRegWrite;
  logic [4:0]  oWriteReg;
  logic [31:0] odata2write2regfile;
  logic [3:0]  oRetired;

  int checks = 0;
  int errors = 0;
  logic [3:0] exp_retired = 4'd0;

  typedef struct packed {
    logic        valid;
    logic        wr;
    logic        memtoreg;
    logic        link;
    logic [1:0]  size;
    logic        uns;
    logic [4:0]  dest;
    logic [31:0] pc;
    logic [31:0] ram;
    logic [31:0] alu;
    logic [31:0] exp_data;
    logic        exp_wr;
  } vec_t;

  vec_t vecs [14];

  mips_writeback_stage #(
    .DATA_WIDTH(32),
    .REG_ADDR_WIDTH(5),
    .LINK_OFFSET(8),
    .CNT_WIDTH(4)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .iValid(iValid),
    .iStall(iStall),
    .iFlush(iFlush),
    .iSig_regfile_write(iSig_regfile_write),
    .iSig_MemtoReg(iSig_MemtoReg),
    .iSig_Link(iSig_Link),
    .iLoadSize(iLoadSize),
    .iLoadUnsigned(iLoadUnsigned),
    .iDest_reg(iDest_reg),
    .iPC(iPC),
    .iread_from_ram(iread_from_ram),
    .ialu_result(ialu_result),
    .oValid(oValid),
    .oRegWrite(oRegWrite),
    .oWriteReg(oWriteReg),
    .odata2write2regfile(odata2write2regfile),
    .oRetired(oRetired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic checkAll(input string tag, input logic v, input logic w, input logic [4:0] d,
                          input logic [31:0] data, input logic [3:0] ret);
    checkOutput({tag, " oValid"}, 32'(oValid), 32'(v));
    checkOutput({tag, " oRegWrite"}, 32'(oRegWrite), 32'(w));
    checkOutput({tag, " oWriteReg"}, 32'(oWriteReg), 32'(d));
    checkOutput({tag, " data"}, odata2write2regfile, data);
    checkOutput({tag, " oRetired"}, 32'(oRetired), 32'(ret));
  endtask

  task automatic setInputs(input vec_t v);
    iValid             = v.valid;
    iSig_regfile_write = v.wr;
    iSig_MemtoReg      = v.memtoreg;
    iSig_Link          = v.link;
    iLoadSize          = v.size;
    iLoadUnsigned      = v.uns;
    iDest_reg          = v.dest;
    iPC                = v.pc;
    iread_from_ram     = v.ram;
    ialu_result        = v.alu;
  endtask

  // Drive one bundle through one edge with the given stall/flush, then
  // advance the counter model and sample just after the edge.
  task automatic applyStimulus(input vec_t v, input logic stall, input logic flush);
    setInputs(v);
    iStall = stall;
    iFlush = flush;
    @(posedge clk);
    if (!flush && !stall && v.valid) exp_retired = exp_retired + 4'd1;
    #1;
  endtask

  vec_t va, vb;

  initial begin
    //          valid wr  m2r link size   uns  dest   pc            ram           alu           exp_data      exp_wr
    vecs[0]  = '{1'b1,1'b1,1'b1,1'b0,2'b00,1'b0,5'd5, 32'h0,        32'h11F23344, 32'h00001001, 32'hFFFFFFF2, 1'b1};
    vecs[1]  = '{1'b1,1'b1,1'b1,1'b0,2'b00,1'b1,5'd6, 32'h0,        32'h11F23344, 32'h00001001, 32'h000000F2, 1'b1};
    vecs[2]  = '{1'b1,1'b1,1'b1,1'b0,2'b00,1'b0,5'd7, 32'h0,        32'h11F23344, 32'h00001003, 32'h00000044, 1'b1};
    vecs[3]  = '{1'b1,1'b1,1'b1,1'b0,2'b01,1'b1,5'd8, 32'h0,        32'h11F23344, 32'h00001003, 32'h00003344, 1'b1};
    vecs[4]  = '{1'b1,1'b1,1'b1,1'b0,2'b01,1'b0,5'd9, 32'h0,        32'h80000000, 32'h00001000, 32'hFFFF8000, 1'b1};
    vecs[5]  = '{1'b1,1'b1,1'b1,1'b0,2'b01,1'b0,5'd10,32'h0,        32'h80000000, 32'h00001002, 32'h00000000, 1'b1};
    vecs[6]  = '{1'b1,1'b1,1'b1,1'b0,2'b10,1'b0,5'd11,32'h0,        32'h89ABCDEF, 32'h00001002, 32'h89ABCDEF, 1'b1};
    vecs[7]  = '{1'b1,1'b1,1'b1,1'b0,2'b11,1'b1,5'd12,32'h0,        32'h89ABCDEF, 32'h00001000, 32'h89ABCDEF, 1'b1};
    vecs[8]  = '{1'b1,1'b1,1'b0,1'b0,2'b00,1'b0,5'd13,32'h0,        32'h11F23344, 32'hDEADBEEF, 32'hDEADBEEF, 1'b1};
    vecs[9]  = '{1'b1,1'b1,1'b1,1'b1,2'b10,1'b0,5'd31,32'h00400010, 32'h11F23344, 32'h00001000, 32'h00400018, 1'b1};
    vecs[10] = '{1'b1,1'b1,1'b0,1'b0,2'b00,1'b0,5'd0, 32'h0,        32'h0,        32'h12345678, 32'h12345678, 1'b0};
    vecs[11] = '{1'b0,1'b1,1'b0,1'b0,2'b00,1'b0,5'd7, 32'h0,        32'h0,        32'h0000ABCD, 32'h0000ABCD, 1'b0};
    vecs[12] = '{1'b1,1'b0,1'b0,1'b0,2'b00,1'b0,5'd7, 32'h0,        32'h0,        32'h00005555, 32'h00005555, 1'b0};
    vecs[13] = '{1'b1,1'b1,1'b1,1'b0,2'b00,1'b1,5'd2, 32'h0,        32'hA5F23344, 32'h00002000, 32'h000000A5, 1'b1};

    rstn   = 1'b0;
    iStall = 1'b0;
    iFlush = 1'b0;
    setInputs('0);
    #12;
    checkAll("reset", 1'b0, 1'b0, 5'd0, 32'h0, 4'd0);
    rstn = 1'b1;

    // Table-driven datapath vectors
    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i], 1'b0, 1'b0);
      checkAll($sformatf("vec%0d", i), vecs[i].valid, vecs[i].exp_wr, vecs[i].dest,
               vecs[i].exp_data, exp_retired);
    end

    // Stall holds A while B is presented
    va = '{1'b1,1'b1,1'b0,1'b0,2'b00,1'b0,5'd3,32'h0,32'h0,32'h11111111,32'h11111111,1'b1};
    vb = '{1'b1,1'b1,1'b0,1'b0,2'b00,1'b0,5'd9,32'h0,32'h0,32'h22222222,32'h22222222,1'b1};
    applyStimulus(va, 1'b0, 1'b0);
    checkAll("captureA", 1'b1, 1'b1, 5'd3, 32'h11111111, exp_retired);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(vb, 1'b1, 1'b0);
      checkAll($sformatf("stall%0d", i), 1'b1, 1'b1, 5'd3, 32'h11111111, exp_retired);
    end

    // Flush beats stall: valid drops, payload held
    applyStimulus(vb, 1'b1, 1'b1);
    checkAll("flushstall", 1'b0, 1'b0, 5'd3, 32'h11111111, exp_retired);
    applyStimulus(vb, 1'b0, 1'b0);
    checkAll("captureB", 1'b1, 1'b1, 5'd9, 32'h22222222, exp_retired);

    // Mid-cycle reset while valid, with stall and flush asserted
    iStall = 1'b1;
    iFlush = 1'b1;
    #3;
    rstn = 1'b0;
    #1;
    checkAll("asyncreset", 1'b0, 1'b0, 5'd0, 32'h0, 4'd0);
    @(posedge clk);
    #1;
    checkAll("resethold", 1'b0, 1'b0, 5'd0, 32'h0, 4'd0);
    rstn = 1'b1;
    exp_retired = 4'd0;

    // Counter wrap after 16 valid captures
    for (int i = 0; i < 15; i++) applyStimulus(va, 1'b0, 1'b0);
    checkOutput("retired15", 32'(oRetired), 32'(exp_retired));
    checkOutput("retired15abs", 32'(oRetired), 32'd15);
    applyStimulus(va, 1'b0, 1'b0);
    checkOutput("retiredwrap", 32'(oRetired), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
